adc_scan: RTL and testbench
===========================

# adc_scan

Scan sequencer and sample holder sitting directly downstream of the serial accelerometer ADC interface in `wb_adc`. It steps the ADC channel select through X, Y and Z and re-arms the ADC for each conversion. It captures each 8-bit result on the rising edge of the ADC's done flag and presents one coherent three-axis frame to the Wishbone register layer, with a one-cycle frame strobe.

## Interface
Parameters:
- `FRAME_GAP`, default 1000: idle cycles between the end of one frame and the start of the next.
- `TIMEOUT`, default 4095: maximum cycles spent waiting for `adc_done` per channel.
- `AVG_SHIFT`, default 2: IIR filter shift. Used only when `ADC_SCAN_AVG_EN` is defined; legal range 1..7.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `enable`, in, 1: continuous scanning while high.
- `err_clr`, in, 1: clears `timeout_err`.
- `adc_done`, in, 1: conversion-complete level from the ADC.
- `adc_data`, in, 8: conversion result. Valid while `adc_done` is high.
- `adc_rst`, out, 1: ADC re-arm. Reset value 1.
- `adc_di`, out, 2: channel select, 0 = X, 1 = Y, 2 = Z; 3 is never driven. Reset value 0.
- `ax`, `ay`, `az`, out, 8 each: latest axis values. Reset value 0.
- `frame_valid`, out, 1: one-cycle pulse when a frame completes. Reset value 0.
- `timeout_err`, out, 1: sticky error flag. Reset value 0.
- `busy`, out, 1: high in any state other than IDLE. Reset value 0.

## Operation
- FSM states: IDLE, SEL, REARM, WAIT, STORE, NEXT, GAP. Reset enters IDLE.
- IDLE:
  - `adc_rst`=1, `adc_di`=0.
  - `enable`=1 moves to SEL with channel counter `ch`=0.
- SEL: drive `adc_di`=`ch` with `adc_rst`=1. Move to REARM.
- REARM: `adc_rst`=1 for exactly one more cycle, then WAIT. The channel select is therefore stable for two cycles before the ADC is released.
- WAIT:
  - `adc_rst`=0. The timeout counter is cleared on entry.
  - A rising edge of `adc_done` (`adc_done`=1 while the registered `done_q`=0) moves to STORE and latches `adc_data` into the capture register.
  - If `TIMEOUT` cycles pass without an edge: set `timeout_err`, keep the previous axis value, move to NEXT.
- STORE: write the captured byte into `ax`/`ay`/`az` according to `ch`, raw or filtered. Move to NEXT.
- NEXT:
  - If `ch`<2: increment `ch`, go to SEL.
  - Otherwise pulse `frame_valid`, load the gap counter with `FRAME_GAP`, go to GAP.
- GAP:
  - `adc_rst`=1 while counting down.
  - At 0: go to SEL with `ch`=0 if `enable`=1, else IDLE.
- `enable` dropping mid-frame does not abort the frame. The current frame completes, including `frame_valid`, then the block returns to IDLE after GAP.
- Axis outputs change only in STORE. All three outputs are stable from the `frame_valid` pulse until the next STORE of X.
- `err_clr` and a new timeout in the same cycle: the set wins.
- `rst` mid-operation:
  - All outputs return to their reset values on the next edge, the filter seed flags clear, and the FSM goes to IDLE.
  - A partial frame is discarded and no `frame_valid` is issued.

## Timing
- From `enable` rising in IDLE to the first `adc_rst` deassertion: 3 cycles (IDLE→SEL→REARM→WAIT).
- From the `adc_done` rising edge to axis output update: 2 cycles (edge seen in WAIT, written in STORE).
- `frame_valid` is asserted 1 cycle after the Z STORE.
- Frame period: 3×(4 + ADC conversion cycles) + FRAME_GAP + 1.
- `adc_done` already high on entry to WAIT is not an edge because `done_q` tracks it. The block waits for a fresh conversion or times out.

## Configuration
- `ADC_SCAN_AVG_EN` defined:
  - Each axis is a first-order IIR: y ← y + ((x − y) >>> `AVG_SHIFT`).
  - The difference is 9-bit signed and the arithmetic shift keeps the result within 0..255, so no saturation is needed.
  - The first sample after reset loads y directly (seed flag per axis).
- `ADC_SCAN_AVG_EN` undefined: STORE writes the raw capture. The filter logic and seed flags are absent.

## Structure
- Shared package `adc_pkg`:
  - channel encodings `CH_X`=0, `CH_Y`=1, `CH_Z`=2;
  - FSM state enum;
  - widths `ADC_W`=8 and `CH_W`=2.
- Sub-module `adc_scan_filter`: one per axis, instantiated only under `ADC_SCAN_AVG_EN`. It has inputs `clk`, `rst`, `load`, `x`[7:0] and output `y`[7:0], and contains the seed flag.

## Test plan
- Reset, then `enable`=1. A model ADC asserts `adc_done` 20 cycles after `adc_rst` falls, returning 0x11/0x22/0x33 for `di`=0/1/2.
  - Expect `ax`=0x11, `ay`=0x22, `az`=0x33 and one `frame_valid` pulse.
  - Expect `adc_di` sequence 0,1,2.
- Model ADC never asserts done for Y.
  - Expect `timeout_err`=1 after `TIMEOUT` cycles in WAIT.
  - Expect `ay` to hold its old value, Z still to be sampled, and `frame_valid` still to pulse.
  - `err_clr` then clears the flag.
- `adc_done` held high from before WAIT.
  - Expect no capture until done falls and rises again.
- `enable` dropped during the Y conversion.
  - Expect the frame to finish, `frame_valid`=1, then IDLE with `adc_rst`=1 and `busy`=0.
- `rst` asserted during WAIT for Z.
  - Expect all outputs 0 on the next cycle and no `frame_valid`.
- With `ADC_SCAN_AVG_EN` and `AVG_SHIFT`=2, feed X samples 200 then 100.
  - Expect `ax`=200, then 175.

Source files
------------

// File: rtl/adc_pkg.sv
//==============================================================================
// Module      : adc_pkg
// Description : Shared definitions for the accelerometer scan sequencer:
//               data/channel widths, channel encodings and the scan FSM
//               state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package adc_pkg;

   // ADC result width and channel-select width
   localparam int ADC_W = 8;
   localparam int CH_W  = 2;

   // Channel-select encodings driven on adc_di (3 is never driven)
   localparam logic [CH_W-1:0] CH_X = 2'd0;
   localparam logic [CH_W-1:0] CH_Y = 2'd1;
   localparam logic [CH_W-1:0] CH_Z = 2'd2;

   // Scan sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEL   = 3'd1,
      ST_REARM = 3'd2,
      ST_WAIT  = 3'd3,
      ST_STORE = 3'd4,
      ST_NEXT  = 3'd5,
      ST_GAP   = 3'd6
   } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/adc_scan_filter.sv
//==============================================================================
// Module      : adc_scan_filter
// Description : First-order IIR smoother for one accelerometer axis:
//                  y <= y + ((x - y) >>> AVG_SHIFT)
//               The first load after reset seeds y with x directly.
//               Only instantiated when ADC_SCAN_AVG_EN is defined.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset (clears y and seed flag)
//               load - apply one new sample x
//               x    - new raw sample
//               y    - filtered value (registered)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module adc_scan_filter
   import adc_pkg::*;
#(
   parameter int AVG_SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [ADC_W-1:0] x,
   output logic [ADC_W-1:0] y
);

   logic                    r_seeded;
   logic signed [ADC_W:0]   w_diff;
   logic        [ADC_W-1:0] w_step;
   logic        [ADC_W-1:0] w_next;

   // The difference needs one extra bit for its sign. The arithmetic shift
   // rounds towards minus infinity, so y + step always lies between y and x
   // and the 8-bit modular sum below never wraps.
   assign w_diff = $signed({1'b0, x}) - $signed({1'b0, y});
   assign w_step = ADC_W'(w_diff >>> AVG_SHIFT);
   assign w_next = y + w_step;

   always_ff @(posedge clk) begin
      if (rst) begin
         y        <= '0;
         r_seeded <= 1'b0;
      end else if (load) begin
         y        <= r_seeded ? w_next : x;
         r_seeded <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/adc_scan.sv
//==============================================================================
// Module      : adc_scan
// Description : Scan sequencer and sample holder for the serial accelerometer
//               ADC. Steps the channel select through X, Y, Z, re-arms the
//               ADC for every conversion, captures each result on the rising
//               edge of adc_done and presents a coherent three-axis frame
//               with a one-cycle frame_valid strobe, followed by an idle gap.
// Config      : ADC_SCAN_AVG_EN - when defined each axis is passed through a
//               first-order IIR filter (adc_scan_filter) with shift
//               AVG_SHIFT; otherwise the raw capture is stored.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               enable         - continuous scanning while high
//               err_clr        - clears the sticky timeout_err flag
//               adc_done       - conversion-complete level from the ADC
//               adc_data       - conversion result, valid with adc_done
//               adc_rst        - ADC re-arm (low only while waiting)
//               adc_di         - channel select 0=X, 1=Y, 2=Z
//               ax, ay, az     - latest axis values
//               frame_valid    - one-cycle pulse at frame completion
//               timeout_err    - sticky conversion timeout flag
//               busy           - high whenever the sequencer is not idle
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module adc_scan
   import adc_pkg::*;
#(
   parameter int FRAME_GAP = 1000,
   parameter int TIMEOUT   = 4095,
   parameter int AVG_SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             err_clr,
   input  logic             adc_done,
   input  logic [ADC_W-1:0] adc_data,
   output logic             adc_rst,
   output logic [CH_W-1:0]  adc_di,
   output logic [ADC_W-1:0] ax,
   output logic [ADC_W-1:0] ay,
   output logic [ADC_W-1:0] az,
   output logic             frame_valid,
   output logic             timeout_err,
   output logic             busy
);

   // One down/up counter serves both the WAIT timeout and the GAP countdown,
   // so it is sized for the larger of the two.
   localparam int c_cnt_max = (FRAME_GAP > TIMEOUT) ? FRAME_GAP : TIMEOUT;
   localparam int c_cnt_w   = (c_cnt_max < 1) ? 1 : $clog2(c_cnt_max + 1);

   localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(TIMEOUT - 1);
   localparam logic [c_cnt_w-1:0] c_gap_load = c_cnt_w'(FRAME_GAP);

   generate
      if (AVG_SHIFT < 1 || AVG_SHIFT > 7) begin : g_bad_avg_shift
         $error("adc_scan: AVG_SHIFT must be in 1..7");
      end
      if (TIMEOUT < 1) begin : g_bad_timeout
         $error("adc_scan: TIMEOUT must be at least 1");
      end
   endgenerate

   scan_state_t          r_state;
   logic [CH_W-1:0]      r_ch;
   logic [c_cnt_w-1:0]   r_cnt;
   logic                 r_done_q;
   logic [ADC_W-1:0]     r_cap;
   logic                 w_done_rise;

   // done_q follows adc_done in every state, so a level already high when
   // WAIT is entered is not mistaken for a fresh conversion.
   assign w_done_rise = adc_done & ~r_done_q;

   //--------------------------------------------------------------------------
   // Sequencer with registered outputs: every output is updated on the
   // transition into the state that owns its value.
   //--------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ch        <= CH_X;
         r_cnt       <= '0;
         r_done_q    <= 1'b0;
         r_cap       <= '0;
         adc_rst     <= 1'b1;
         adc_di      <= CH_X;
         frame_valid <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
`ifndef ADC_SCAN_AVG_EN
         ax          <= '0;
         ay          <= '0;
         az          <= '0;
`endif
      end else begin
         r_done_q    <= adc_done;
         frame_valid <= 1'b0;

         // Clear first so that a timeout raised below in the same cycle wins.
         if (err_clr) begin
            timeout_err <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               adc_rst <= 1'b1;
               adc_di  <= CH_X;
               if (enable) begin
                  r_ch    <= CH_X;
                  busy    <= 1'b1;
                  r_state <= ST_SEL;
               end
            end

            ST_SEL: begin
               r_state <= ST_REARM;
            end

            // Channel select has now been stable for two cycles; release ADC.
            ST_REARM: begin
               adc_rst <= 1'b0;
               r_cnt   <= '0;
               r_state <= ST_WAIT;
            end

            ST_WAIT: begin
               if (w_done_rise) begin
                  r_cap   <= adc_data;
                  adc_rst <= 1'b1;
                  r_state <= ST_STORE;
               end else if (r_cnt == c_to_last) begin
                  // Abandon this channel; the axis keeps its previous value.
                  timeout_err <= 1'b1;
                  adc_rst     <= 1'b1;
                  r_state     <= ST_NEXT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_STORE: begin
`ifndef ADC_SCAN_AVG_EN
               case (r_ch)
                  CH_X:    ax <= r_cap;
                  CH_Y:    ay <= r_cap;
                  CH_Z:    az <= r_cap;
                  default: ;
               endcase
`endif
               r_state <= ST_NEXT;
            end

            ST_NEXT: begin
               if (r_ch < CH_Z) begin
                  r_ch    <= r_ch + 2'd1;
                  adc_di  <= r_ch + 2'd1;
                  r_state <= ST_SEL;
               end else begin
                  frame_valid <= 1'b1;
                  r_cnt       <= c_gap_load;
                  r_state     <= ST_GAP;
               end
            end

            // enable is only sampled here, so dropping it mid-frame lets the
            // current frame run to completion.
            ST_GAP: begin
               adc_rst <= 1'b1;
               if (r_cnt == '0) begin
                  r_ch   <= CH_X;
                  adc_di <= CH_X;
                  if (enable) begin
                     r_state <= ST_SEL;
                  end else begin
                     busy    <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            default: begin
               adc_rst <= 1'b1;
               adc_di  <= CH_X;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ADC_SCAN_AVG_EN
   //--------------------------------------------------------------------------
   // Filtered axes: each filter updates on the same edge a raw store would.
   //--------------------------------------------------------------------------
   logic w_store;
   logic w_load_x;
   logic w_load_y;
   logic w_load_z;

   assign w_store  = (r_state == ST_STORE);
   assign w_load_x = w_store && (r_ch == CH_X);
   assign w_load_y = w_store && (r_ch == CH_Y);
   assign w_load_z = w_store && (r_ch == CH_Z);

   adc_scan_filter #(.AVG_SHIFT(AVG_SHIFT)) u_filt_x (
      .clk  (clk),
      .rst  (rst),
      .load (w_load_x),
      .x    (r_cap),
      .y    (ax)
   );

   adc_scan_filter #(.AVG_SHIFT(AVG_SHIFT)) u_filt_y (
      .clk  (clk),
      .rst  (rst),
      .load (w_load_y),
      .x    (r_cap),
      .y    (ay)
   );

   adc_scan_filter #(.AVG_SHIFT(AVG_SHIFT)) u_filt_z (
      .clk  (clk),
      .rst  (rst),
      .load (w_load_z),
      .x    (r_cap),
      .y    (az)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_adc_scan.sv
//==============================================================================
// Module      : tb_adc_scan
// Description : Self-checking bench for adc_scan. A behavioural ADC answers
//               each conversion; expected frames and channel-select values
//               are queued by the tests and compared when the DUT produces
//               frame_valid or releases adc_rst.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_adc_scan;
   import adc_pkg::*;

   localparam int FRAME_GAP = 10;
   localparam int TIMEOUT   = 64;
   localparam int AVG_SHIFT = 2;
   localparam int DONE_DLY  = 20;
   localparam int WAIT_MAX  = 3000;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       enable   = 1'b0;
   logic       err_clr  = 1'b0;
   logic       adc_done = 1'b0;
   logic [7:0] adc_data = 8'h00;
   logic       adc_rst;
   logic [1:0] adc_di;
   logic [7:0] ax, ay, az;
   logic       frame_valid, timeout_err, busy;

   int n_checks = 0;
   int n_errors = 0;
   int n_frames = 0;

   logic [23:0] exp_q[$];
   logic [1:0]  di_q[$];

   logic [7:0] lut [0:2];
   bit         block_y   = 1'b0;
   bit         hold_done = 1'b0;
   int         adc_cnt   = 0;

   // Reference axis model
   logic [7:0] m_ax = 8'h00, m_ay = 8'h00, m_az = 8'h00;
   bit         m_sx = 1'b0, m_sy = 1'b0, m_sz = 1'b0;

   adc_scan #(
      .FRAME_GAP (FRAME_GAP),
      .TIMEOUT   (TIMEOUT),
      .AVG_SHIFT (AVG_SHIFT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .err_clr     (err_clr),
      .adc_done    (adc_done),
      .adc_data    (adc_data),
      .adc_rst     (adc_rst),
      .adc_di      (adc_di),
      .ax          (ax),
      .ay          (ay),
      .az          (az),
      .frame_valid (frame_valid),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   //--------------------------------------------------------------------------
   // Behavioural ADC: done rises DONE_DLY cycles after adc_rst falls and is
   // cleared whenever adc_rst is high. hold_done hands adc_done to a test.
   //--------------------------------------------------------------------------
   always @(posedge clk) begin
      #1;
      if (!hold_done) begin
         if (adc_rst) begin
            adc_cnt  = 0;
            adc_done = 1'b0;
         end else begin
            adc_cnt++;
            if (adc_cnt == DONE_DLY && !(block_y && adc_di == 2'd1)) begin
               adc_data = lut[adc_di];
               adc_done = 1'b1;
            end
         end
      end
   end

   //--------------------------------------------------------------------------
   // Scoreboard monitor
   //--------------------------------------------------------------------------
   logic        prev_adc_rst = 1'b1;
   logic [23:0] exp_frame;
   logic [1:0]  exp_di;

   always @(negedge clk) begin
      if (!rst && frame_valid === 1'b1) begin
         n_frames++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL frame_unexpected: got ax=%02h ay=%02h az=%02h, no frame expected", ax, ay, az);
         end else begin
            exp_frame = exp_q.pop_front();
            if ({ax, ay, az} !== exp_frame) begin
               n_errors++;
               $display("FAIL frame_data: got %02h/%02h/%02h expected %02h/%02h/%02h",
                        ax, ay, az, exp_frame[23:16], exp_frame[15:8], exp_frame[7:0]);
            end
         end
      end
      if (prev_adc_rst === 1'b1 && adc_rst === 1'b0) begin
         n_checks++;
         if (di_q.size() == 0) begin
            n_errors++;
            $display("FAIL adc_di_unexpected: conversion started on di=%0d, none expected", adc_di);
         end else begin
            exp_di = di_q.pop_front();
            if (adc_di !== exp_di) begin
               n_errors++;
               $display("FAIL adc_di_seq: got %0d expected %0d", adc_di, exp_di);
            end
         end
      end
      prev_adc_rst = adc_rst;
   end

   //--------------------------------------------------------------------------
   // Model helpers
   //--------------------------------------------------------------------------
   function automatic logic [7:0] filt(input logic [7:0] y, input logic [7:0] x, input bit seeded);
`ifdef ADC_SCAN_AVG_EN
      int d;
      if (!seeded) return x;
      d = int'(x) - int'(y);
      return 8'(int'(y) + (d >>> AVG_SHIFT));
`else
      return x;
`endif
   endfunction

   task automatic model_store(input int ch, input logic [7:0] v);
      case (ch)
         0: begin m_ax = filt(m_ax, v, m_sx); m_sx = 1'b1; end
         1: begin m_ay = filt(m_ay, v, m_sy); m_sy = 1'b1; end
         default: begin m_az = filt(m_az, v, m_sz); m_sz = 1'b1; end
      endcase
   endtask

   task automatic model_reset();
      m_ax = 8'h00; m_ay = 8'h00; m_az = 8'h00;
      m_sx = 1'b0;  m_sy = 1'b0;  m_sz = 1'b0;
   endtask

   task automatic push_frame();
      exp_q.push_back({m_ax, m_ay, m_az});
   endtask

   task automatic push_di();
      di_q.push_back(2'd0);
      di_q.push_back(2'd1);
      di_q.push_back(2'd2);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_conv(input logic [1:0] ch);
      int n = 0;
      while (!(busy === 1'b1 && adc_rst === 1'b0 && adc_di === ch) && n < WAIT_MAX) begin
         tick();
         n++;
      end
      n_checks++;
      if (n >= WAIT_MAX) begin
         n_errors++;
         $display("FAIL wait_conv: channel %0d conversion not reached in %0d cycles", ch, WAIT_MAX);
      end
   endtask

   task automatic wait_frames(input int target);
      int n = 0;
      while (n_frames < target && n < WAIT_MAX) begin
         tick();
         n++;
      end
      n_checks++;
      if (n_frames < target) begin
         n_errors++;
         $display("FAIL wait_frames: saw %0d frames, required %0d", n_frames, target);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < WAIT_MAX) begin
         tick();
         n++;
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, WAIT_MAX);
      end
   endtask

   //--------------------------------------------------------------------------
   // Tests
   //--------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_checks += 7;
      if (adc_rst !== 1'b1)     begin n_errors++; $display("FAIL reset_adc_rst: got %b required 1", adc_rst); end
      if (adc_di !== 2'd0)      begin n_errors++; $display("FAIL reset_adc_di: got %0d required 0", adc_di); end
      if (ax !== 8'h00)         begin n_errors++; $display("FAIL reset_ax: got %02h required 00", ax); end
      if (ay !== 8'h00)         begin n_errors++; $display("FAIL reset_ay: got %02h required 00", ay); end
      if (az !== 8'h00)         begin n_errors++; $display("FAIL reset_az: got %02h required 00", az); end
      if (frame_valid !== 1'b0 || timeout_err !== 1'b0)
                                begin n_errors++; $display("FAIL reset_flags: got fv=%b err=%b required 0/0", frame_valid, timeout_err); end
      if (busy !== 1'b0)        begin n_errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_normal();
      int n = 0;
      int nf;
      model_store(0, lut[0]); model_store(1, lut[1]); model_store(2, lut[2]);
      push_frame();
      push_di();
      nf = n_frames;
      enable = 1'b1;
      do begin
         tick();
         n++;
      end while (adc_rst === 1'b1 && n < 10);
      n_checks += 2;
      if (n !== 3)       begin n_errors++; $display("FAIL enable_latency: adc_rst fell after %0d cycles, required 3", n); end
      if (busy !== 1'b1) begin n_errors++; $display("FAIL busy_active: got %b required 1", busy); end
      wait_frames(nf + 1);
      enable = 1'b0;
      wait_idle();
      n_checks += 2;
      if (n_frames !== nf + 1)          begin n_errors++; $display("FAIL normal_frame_count: got %0d required %0d", n_frames, nf + 1); end
      if ({ax, ay, az} !== {m_ax, m_ay, m_az})
                                        begin n_errors++; $display("FAIL normal_hold: got %06h required %06h", {ax, ay, az}, {m_ax, m_ay, m_az}); end
   endtask

   task automatic test_timeout();
      int n = 0;
      int nf;
      block_y = 1'b1;
      model_store(0, lut[0]); model_store(2, lut[2]);
      push_frame();
      push_di();
      nf = n_frames;
      enable = 1'b1;
      wait_conv(2'd1);
      while (timeout_err !== 1'b1 && n < TIMEOUT + 10) begin
         tick();
         n++;
      end
      n_checks += 2;
      if (n !== TIMEOUT) begin n_errors++; $display("FAIL timeout_cycles: flag after %0d cycles, required %0d", n, TIMEOUT); end
      if (ay !== m_ay)   begin n_errors++; $display("FAIL timeout_ay_hold: got %02h required %02h", ay, m_ay); end
      wait_frames(nf + 1);
      enable = 1'b0;
      wait_idle();
      block_y = 1'b0;
      n_checks++;
      if (timeout_err !== 1'b1) begin n_errors++; $display("FAIL timeout_sticky: got %b required 1", timeout_err); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_checks++;
      if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL err_clr: got %b required 0", timeout_err); end
   endtask

   task automatic test_hold();
      int nf;
      logic [7:0] old_ax;
      old_ax = m_ax;
      hold_done = 1'b1;
      adc_done  = 1'b1;
      adc_data  = 8'h5A;
      model_store(0, 8'h5A); model_store(1, lut[1]); model_store(2, lut[2]);
      push_frame();
      push_di();
      nf = n_frames;
      enable = 1'b1;
      wait_conv(2'd0);
      repeat (30) tick();
      n_checks += 2;
      if (adc_rst !== 1'b0) begin n_errors++; $display("FAIL hold_no_capture: adc_rst=%b required 0 while done held", adc_rst); end
      if (ax !== old_ax)    begin n_errors++; $display("FAIL hold_ax: got %02h required %02h", ax, old_ax); end
      adc_done = 1'b0;
      repeat (2) tick();
      adc_done = 1'b1;
      tick();
      n_checks++;
      if (adc_rst !== 1'b1) begin n_errors++; $display("FAIL hold_edge_capture: adc_rst=%b required 1 one cycle after rise", adc_rst); end
      hold_done = 1'b0;
      tick();
      n_checks++;
      if (ax !== m_ax)      begin n_errors++; $display("FAIL store_latency: ax=%02h required %02h two cycles after rise", ax, m_ax); end
      wait_frames(nf + 1);
      enable = 1'b0;
      wait_idle();
   endtask

   task automatic test_enable_drop();
      int nf;
      model_store(0, lut[0]); model_store(1, lut[1]); model_store(2, lut[2]);
      push_frame();
      push_di();
      nf = n_frames;
      enable = 1'b1;
      wait_conv(2'd1);
      enable = 1'b0;
      wait_frames(nf + 1);
      wait_idle();
      n_checks += 2;
      if (adc_rst !== 1'b1) begin n_errors++; $display("FAIL drop_adc_rst: got %b required 1", adc_rst); end
      if (adc_di !== 2'd0)  begin n_errors++; $display("FAIL drop_adc_di: got %0d required 0", adc_di); end
      repeat (FRAME_GAP + 60) tick();
      n_checks++;
      if (n_frames !== nf + 1) begin n_errors++; $display("FAIL drop_frame_count: got %0d required %0d", n_frames, nf + 1); end
   endtask

   task automatic test_rst_mid();
      int nf;
      push_di();
      nf = n_frames;
      enable = 1'b1;
      wait_conv(2'd2);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      model_reset();
      n_checks += 3;
      if ({ax, ay, az} !== 24'h0)   begin n_errors++; $display("FAIL rst_mid_axes: got %06h required 000000", {ax, ay, az}); end
      if (adc_rst !== 1'b1 || adc_di !== 2'd0)
                                    begin n_errors++; $display("FAIL rst_mid_adc: got rst=%b di=%0d required 1/0", adc_rst, adc_di); end
      if (busy !== 1'b0 || frame_valid !== 1'b0 || timeout_err !== 1'b0)
                                    begin n_errors++; $display("FAIL rst_mid_flags: got busy=%b fv=%b err=%b required 0/0/0", busy, frame_valid, timeout_err); end
      enable = 1'b0;
      tick();
      rst = 1'b0;
      repeat (FRAME_GAP + 100) tick();
      n_checks++;
      if (n_frames !== nf) begin n_errors++; $display("FAIL rst_mid_no_frame: got %0d frames required %0d", n_frames, nf); end
   endtask

`ifdef ADC_SCAN_AVG_EN
   task automatic test_avg();
      int nf;
      lut[0] = 8'd200;
      model_store(0, lut[0]); model_store(1, lut[1]); model_store(2, lut[2]);
      push_frame();
      push_di();
      nf = n_frames;
      enable = 1'b1;
      wait_frames(nf + 1);
      enable = 1'b0;
      wait_idle();
      n_checks++;
      if (ax !== 8'd200) begin n_errors++; $display("FAIL avg_seed: ax=%0d required 200", ax); end
      lut[0] = 8'd100;
      model_store(0, lut[0]); model_store(1, lut[1]); model_store(2, lut[2]);
      push_frame();
      push_di();
      enable = 1'b1;
      wait_frames(nf + 2);
      enable = 1'b0;
      wait_idle();
      n_checks++;
      if (ax !== 8'd175) begin n_errors++; $display("FAIL avg_step: ax=%0d required 175", ax); end
      lut[0] = 8'h11;
   endtask
`endif

   task automatic test_drain();
      n_checks++;
      if (exp_q.size() != 0 || di_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: %0d frames and %0d selects left, required 0/0", exp_q.size(), di_q.size());
      end
   endtask

   initial begin
      lut[0] = 8'h11;
      lut[1] = 8'h22;
      lut[2] = 8'h33;
      test_reset();
      test_normal();
      test_timeout();
      test_hold();
      test_enable_drop();
      test_rst_mid();
`ifdef ADC_SCAN_AVG_EN
      test_avg();
`endif
      test_drain();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
